// File: rtl/apb_soc_ctrl.sv
// APB SoC control / pad-configuration register block.
// Optional scratch register at 0x020 enabled by APB_SOC_CTRL_SCRATCH_EN.
module apb_soc_ctrl #(
    parameter int          APB_ADDR_WIDTH  = 12,
    parameter logic [31:0] BOOT_ADDR       = 32'h8000,
    parameter int          N_PADS          = 32,
    parameter int          PAD_CFG_W       = 6,
    parameter int          READ_WAIT       = 0,
    parameter int          SOFT_RST_CYCLES = 16,
    parameter logic [31:0] UNLOCK_KEY      = 32'h5A5A_C0DE
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
    input  logic [31:0]                   PWDATA,
    input  logic                          PWRITE,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    output logic [31:0]                   PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [N_PADS*PAD_CFG_W-1:0]   pad_cfg_o,
    output logic [N_PADS-1:0]             pad_mux_o,
    output logic [31:0]                   clk_gate_o,
    output logic [31:0]                   boot_addr_o,
    output logic                          soft_rst_o,
    output logic                          lock_o
);

    localparam int WW  = APB_ADDR_WIDTH - 2;
    localparam int NCW = (N_PADS + 3) / 4;
    localparam int CW  = N_PADS * PAD_CFG_W;
`ifdef APB_SOC_CTRL_SCRATCH_EN
    localparam logic SCR_EN = 1'b1;
`else
    localparam logic SCR_EN = 1'b0;
`endif
    localparam logic [31:0] INFO =
        {7'd0, SCR_EN, 4'd0, 4'(PAD_CFG_W), 8'(N_PADS), 8'h02};

    logic [N_PADS-1:0] pad_mux_q, pad_mux_d;
    logic [CW-1:0]     pad_cfg_q, pad_cfg_d;
    logic [31:0]       clk_gate_q, clk_gate_d;
    logic [31:0]       boot_addr_q, boot_addr_d;
    logic [1:0]        status_q, status_d;
    logic              err_q, err_d;
    logic              lock_q, lock_d;
    logic [7:0]        srst_q, srst_d;
    logic [2:0]        wait_q, wait_d;
`ifdef APB_SOC_CTRL_SCRATCH_EN
    logic [31:0]       scratch_q, scratch_d;
`endif

    logic [WW-1:0] widx, cfg_k;
    logic sel_mux_lo, sel_mux_hi, sel_clk, sel_boot, sel_info;
    logic sel_status, sel_lock, sel_srst, sel_scr, sel_cfg, mapped;
    logic rd_phase, pready, access, wr_en, rd_en, busy;
    logic wr_err, slverr;
    logic [31:0] rdata;
    logic unused_addr;

    assign unused_addr = ^PADDR[1:0];
    assign widx        = PADDR[APB_ADDR_WIDTH-1:2];
    assign cfg_k       = widx - WW'(64);
    assign sel_mux_lo  = widx == WW'(0);
    assign sel_mux_hi  = widx == WW'(1);
    assign sel_clk     = widx == WW'(2);
    assign sel_boot    = widx == WW'(3);
    assign sel_info    = widx == WW'(4);
    assign sel_status  = widx == WW'(5);
    assign sel_lock    = widx == WW'(6);
    assign sel_srst    = widx == WW'(7);
    assign sel_scr     = SCR_EN && (widx == WW'(8));
    assign sel_cfg     = (widx >= WW'(64)) && (widx < WW'(64 + NCW));
    assign mapped      = sel_mux_lo | sel_mux_hi | sel_clk | sel_boot |
                         sel_info | sel_status | sel_lock | sel_srst |
                         sel_scr | sel_cfg;

    assign rd_phase = PSEL & PENABLE & ~PWRITE;
    assign pready   = ~rd_phase | (wait_q == 3'(READ_WAIT));
    assign access   = PSEL & PENABLE & pready;
    assign wr_en    = access & PWRITE;
    assign rd_en    = access & ~PWRITE;
    assign busy     = srst_q != 8'd0;

    // Read wait-state counter, held at zero outside a stalled read
    always_comb begin
        wait_d = 3'd0;
        if (rd_phase && !pready) wait_d = wait_q + 3'd1;
    end

    // Read data mux for the addressed word
    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            sel_mux_lo: begin
                for (int i = 0; i < N_PADS; i++)
                    if (i < 32) rdata[i % 32] = pad_mux_q[i];
            end
            sel_mux_hi: begin
                for (int i = 0; i < N_PADS; i++)
                    if (i >= 32) rdata[i % 32] = pad_mux_q[i];
            end
            sel_clk:    rdata = clk_gate_q;
            sel_boot:   rdata = boot_addr_q;
            sel_info:   rdata = INFO;
            sel_status: rdata = {23'd0, err_q, 6'd0, status_q};
            sel_lock:   rdata = {31'd0, lock_q};
            sel_srst:   rdata = {31'd0, busy};
`ifdef APB_SOC_CTRL_SCRATCH_EN
            sel_scr:    rdata = scratch_q;
`endif
            sel_cfg: begin
                for (int i = 0; i < N_PADS; i++)
                    if (cfg_k == WW'(i / 4))
                        rdata[8*(i%4) +: PAD_CFG_W] =
                            pad_cfg_q[i*PAD_CFG_W +: PAD_CFG_W];
            end
            default: rdata = 32'd0;
        endcase
    end

    // Register write decode, lock enforcement and error generation
    always_comb begin
        pad_mux_d   = pad_mux_q;
        pad_cfg_d   = pad_cfg_q;
        clk_gate_d  = clk_gate_q;
        boot_addr_d = boot_addr_q;
        status_d    = status_q;
        lock_d      = lock_q;
        srst_d      = busy ? srst_q - 8'd1 : 8'd0;
`ifdef APB_SOC_CTRL_SCRATCH_EN
        scratch_d   = scratch_q;
`endif
        wr_err      = 1'b0;
        if (wr_en) begin
            unique case (1'b1)
                sel_mux_lo: begin
                    if (lock_q) wr_err = 1'b1;
                    else
                        for (int i = 0; i < N_PADS; i++)
                            if (i < 32) pad_mux_d[i] = PWDATA[i % 32];
                end
                sel_mux_hi: begin
                    if (lock_q) wr_err = 1'b1;
                    else
                        for (int i = 0; i < N_PADS; i++)
                            if (i >= 32) pad_mux_d[i] = PWDATA[i % 32];
                end
                sel_clk: begin
                    if (lock_q) wr_err = 1'b1;
                    else clk_gate_d = PWDATA;
                end
                sel_boot: begin
                    if (lock_q) wr_err = 1'b1;
                    else boot_addr_d = PWDATA;
                end
                sel_info:   wr_err = 1'b1;
                sel_status: status_d = PWDATA[1:0];
                sel_lock: begin
                    if (PWDATA == UNLOCK_KEY) lock_d = 1'b0;
                    else if (PWDATA == 32'd1) lock_d = 1'b1;
                    else wr_err = 1'b1;
                end
                sel_srst: begin
                    if (PWDATA[0]) begin
                        if (busy) wr_err = 1'b1;
                        else srst_d = 8'(SOFT_RST_CYCLES);
                    end
                end
                sel_scr: begin
`ifdef APB_SOC_CTRL_SCRATCH_EN
                    scratch_d = PWDATA;
`else
                    wr_err = 1'b1;
`endif
                end
                sel_cfg: begin
                    if (lock_q) wr_err = 1'b1;
                    else
                        for (int i = 0; i < N_PADS; i++)
                            if (cfg_k == WW'(i / 4))
                                pad_cfg_d[i*PAD_CFG_W +: PAD_CFG_W] =
                                    PWDATA[8*(i%4) +: PAD_CFG_W];
                end
                default: wr_err = 1'b0;
            endcase
        end
        slverr = access & (~mapped | (PWRITE & wr_err));
        // Set wins over a simultaneous W1C
        err_d  = (err_q & ~(wr_en & sel_status & PWDATA[8])) | slverr;
    end

    // State registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pad_mux_q   <= '0;
            pad_cfg_q   <= '0;
            clk_gate_q  <= 32'hFFFF_FFFF;
            boot_addr_q <= BOOT_ADDR;
            status_q    <= 2'b11;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
            srst_q      <= 8'd0;
            wait_q      <= 3'd0;
`ifdef APB_SOC_CTRL_SCRATCH_EN
            scratch_q   <= 32'd0;
`endif
        end else begin
            pad_mux_q   <= pad_mux_d;
            pad_cfg_q   <= pad_cfg_d;
            clk_gate_q  <= clk_gate_d;
            boot_addr_q <= boot_addr_d;
            status_q    <= status_d;
            err_q       <= err_d;
            lock_q      <= lock_d;
            srst_q      <= srst_d;
            wait_q      <= wait_d;
`ifdef APB_SOC_CTRL_SCRATCH_EN
            scratch_q   <= scratch_d;
`endif
        end
    end

    assign PRDATA      = (rd_en && mapped) ? rdata : 32'd0;
    assign PREADY      = pready;
    assign PSLVERR     = slverr;
    assign pad_cfg_o   = pad_cfg_q;
    assign pad_mux_o   = pad_mux_q;
    assign clk_gate_o  = clk_gate_q;
    assign boot_addr_o = boot_addr_q;
    assign soft_rst_o  = busy;
    assign lock_o      = lock_q;

endmodule

// File: tb/tb_apb_soc_ctrl.sv
// Testbench for apb_soc_ctrl: vector table plus soft-reset/reset sequences.
// Built with READ_WAIT=3, other parameters at their defaults.
module tb_apb_soc_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [191:0] pad_cfg_o;
    logic [31:0] pad_mux_o;
    logic [31:0] clk_gate_o;
    logic [31:0] boot_addr_o;
    logic        soft_rst_o;
    logic        lock_o;

    apb_soc_ctrl #(.READ_WAIT(3)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .pad_cfg_o(pad_cfg_o), .pad_mux_o(pad_mux_o),
        .clk_gate_o(clk_gate_o), .boot_addr_o(boot_addr_o),
        .soft_rst_o(soft_rst_o), .lock_o(lock_o)
    );

    always #5 HCLK = ~HCLK;

`ifdef APB_SOC_CTRL_SCRATCH_EN
    localparam logic [31:0] INFO_EXP = 32'h0106_2002;
`else
    localparam logic [31:0] INFO_EXP = 32'h0006_2002;
`endif

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   nerr = 0;
    int   nchk = 0;

    int run_len = 0;
    int last_len = 0;
    int npulses = 0;

    // Measures each soft-reset pulse length in cycles
    always @(negedge HCLK) begin
        if (soft_rst_o) run_len++;
        else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
            npulses++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic wr,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = d;
        v.exp_rd = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic apb(input logic wr, input logic [11:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic err, output int waits,
                       output logic to);
        rd = '0; err = 1'b0; waits = 0; to = 1'b1;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (PREADY) begin
                rd = PRDATA; err = PSLVERR; to = 1'b0;
                break;
            end
            waits++;
        end
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_wr(input string nm, input logic [11:0] a,
                         input logic [31:0] d, input logic ee);
        logic [31:0] rd; logic err; int w; logic to;
        apb(1'b1, a, d, rd, err, w, to);
        chk({nm, " timeout"}, 32'(to), 32'd0);
        chk({nm, " err"}, 32'(err), 32'(ee));
    endtask

    task automatic do_rd(input string nm, input logic [11:0] a,
                         input logic [31:0] er, input logic ee);
        logic [31:0] rd; logic err; int w; logic to;
        apb(1'b0, a, 32'd0, rd, err, w, to);
        chk({nm, " timeout"}, 32'(to), 32'd0);
        chk({nm, " data"}, rd, er);
        chk({nm, " err"}, 32'(err), 32'(ee));
    endtask

    task automatic wait_pulses(input int n);
        for (int i = 0; i < 60; i++) begin
            if (npulses >= n) break;
            @(negedge HCLK);
        end
        chk("pulse_end", 32'(npulses >= n), 32'd1);
    endtask

    initial begin
        logic [31:0] rd; logic err; int w; logic to;

        add("info",       0, 12'h010, 0, INFO_EXP, 0);
        add("clk_rst",    0, 12'h008, 0, 32'hFFFF_FFFF, 0);
        add("boot_rst",   0, 12'h00C, 0, 32'h0000_8000, 0);
        add("status_rst", 0, 12'h014, 0, 32'h0000_0003, 0);
        add("cfg1_wr",    1, 12'h104, 32'h3F2A_1505, 0, 0);
        add("cfg1_rd",    0, 12'h104, 0, 32'h3F2A_1505, 0);
        add("cfg2_wr",    1, 12'h108, 32'hFFFF_FFFF, 0, 0);
        add("cfg2_rd",    0, 12'h108, 0, 32'h3F3F_3F3F, 0);
        add("cfg7_rd",    0, 12'h11C, 0, 32'h0, 0);
        add("cfg8_rd",    0, 12'h120, 0, 32'h0, 1);
        add("mux_lo_wr",  1, 12'h000, 32'hA5A5_0F0F, 0, 0);
        add("mux_lo_rd",  0, 12'h000, 0, 32'hA5A5_0F0F, 0);
        add("mux_hi_wr",  1, 12'h004, 32'hFFFF_FFFF, 0, 0);
        add("mux_hi_rd",  0, 12'h004, 0, 32'h0, 0);
        add("info_wr",    1, 12'h010, 32'h123, 0, 1);
        add("unmap_rd",   0, 12'h0F0, 0, 32'h0, 1);
        add("lock_wr",    1, 12'h018, 32'h1, 0, 0);
        add("lock_rd",    0, 12'h018, 0, 32'h1, 0);
        add("clk_locked", 1, 12'h008, 32'h0, 0, 1);
        add("clk_keep",   0, 12'h008, 0, 32'hFFFF_FFFF, 0);
        add("cfg_locked", 1, 12'h104, 32'h0, 0, 1);
        add("cfg_keep",   0, 12'h104, 0, 32'h3F2A_1505, 0);
        add("status_err", 0, 12'h014, 0, 32'h0000_0103, 0);
        add("lock_bad",   1, 12'h018, 32'h1234, 0, 1);
        add("lock_hold",  0, 12'h018, 0, 32'h1, 0);
`ifdef APB_SOC_CTRL_SCRATCH_EN
        add("scr_wr_lk",  1, 12'h020, 32'hDEAD_BEEF, 0, 0);
        add("scr_rd",     0, 12'h020, 0, 32'hDEAD_BEEF, 0);
`else
        add("scr_wr",     1, 12'h020, 32'hDEAD_BEEF, 0, 1);
        add("scr_rd",     0, 12'h020, 0, 32'h0, 1);
`endif
        add("unlock",     1, 12'h018, 32'h5A5A_C0DE, 0, 0);
        add("unlock_rd",  0, 12'h018, 0, 32'h0, 0);
        add("clk_wr",     1, 12'h008, 32'h0000_00FF, 0, 0);
        add("clk_rd",     0, 12'h008, 0, 32'h0000_00FF, 0);
        add("boot_wr",    1, 12'h00C, 32'h0000_1000, 0, 0);
        add("boot_rd",    0, 12'h00C, 0, 32'h0000_1000, 0);
        add("w1c",        1, 12'h014, 32'h0000_0100, 0, 0);
        add("status_clr", 0, 12'h014, 0, 32'h0, 0);
        add("status_wr",  1, 12'h014, 32'h0000_0002, 0, 0);
        add("status_rd",  0, 12'h014, 0, 32'h0000_0002, 0);

        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst pad_cfg", 32'(pad_cfg_o == '0), 32'd1);
        chk("rst pad_mux", pad_mux_o, 32'h0);
        chk("rst clk_gate", clk_gate_o, 32'hFFFF_FFFF);
        chk("rst boot", boot_addr_o, 32'h0000_8000);
        chk("rst soft_rst", 32'(soft_rst_o), 32'd0);
        chk("rst lock", 32'(lock_o), 32'd0);
        chk("rst pready", 32'(PREADY), 32'd1);
        chk("rst pslverr", 32'(PSLVERR), 32'd0);
        chk("rst prdata", PRDATA, 32'h0);

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, w, to);
            chk({vecs[i].name, " timeout"}, 32'(to), 32'd0);
            chk({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].wr) chk({vecs[i].name, " waits"}, w, 0);
            else begin
                chk({vecs[i].name, " data"}, rd, vecs[i].exp_rd);
                chk({vecs[i].name, " waits"}, w, 3);
            end
        end

        @(negedge HCLK);
        chk("idle prdata", PRDATA, 32'h0);
        chk("idle pslverr", 32'(PSLVERR), 32'd0);
        chk("pad4", 32'(pad_cfg_o[4*6 +: 6]), 32'h05);
        chk("pad5", 32'(pad_cfg_o[5*6 +: 6]), 32'h15);
        chk("pad6", 32'(pad_cfg_o[6*6 +: 6]), 32'h2A);
        chk("pad7", 32'(pad_cfg_o[7*6 +: 6]), 32'h3F);
        chk("pad8", 32'(pad_cfg_o[8*6 +: 6]), 32'h3F);
        chk("pad12", 32'(pad_cfg_o[12*6 +: 6]), 32'h00);
        chk("pad_mux_o", pad_mux_o, 32'hA5A5_0F0F);
        chk("clk_gate_o", clk_gate_o, 32'h0000_00FF);
        chk("boot_addr_o", boot_addr_o, 32'h0000_1000);
        chk("lock_o", 32'(lock_o), 32'd0);

        do_wr("srst1", 12'h01C, 32'h1, 1'b0);
        chk("srst1 high", 32'(soft_rst_o), 32'd1);
        wait_pulses(1);
        chk("srst1 len", last_len, 16);

        do_wr("srst2", 12'h01C, 32'h1, 1'b0);
        do_wr("srst2 busy", 12'h01C, 32'h1, 1'b1);
        do_wr("srst2 noop", 12'h01C, 32'h0, 1'b0);
        do_rd("srst2 rd", 12'h01C, 32'h1, 1'b0);
        wait_pulses(2);
        chk("srst2 len", last_len, 16);
        do_rd("srst idle rd", 12'h01C, 32'h0, 1'b0);

        do_wr("lock again", 12'h018, 32'h1, 1'b0);
        chk("lock_o set", 32'(lock_o), 32'd1);
        do_wr("srst3", 12'h01C, 32'h1, 1'b0);
        repeat (7) @(negedge HCLK);
        chk("srst3 high", 32'(soft_rst_o), 32'd1);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("hrst soft_rst", 32'(soft_rst_o), 32'd0);
        chk("hrst pready", 32'(PREADY), 32'd1);
        chk("hrst lock", 32'(lock_o), 32'd0);
        chk("hrst clk_gate", clk_gate_o, 32'hFFFF_FFFF);
        chk("hrst boot", boot_addr_o, 32'h0000_8000);
        chk("hrst pad_mux", pad_mux_o, 32'h0);
        do_rd("hrst status", 12'h014, 32'h0000_0003, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
